// File: rtl/dbg_imem_port_if.sv
// Debug instruction-load and core-fetch bus shared by the host loader (master)
// and the instruction store responder (slave).
interface dbg_imem_port_if #(
  parameter int XLEN               = 64,
  parameter int INSTRUCTION_LENGTH = XLEN / 2
);
  logic                          dbg_wr_en;
  logic [INSTRUCTION_LENGTH-1:0] dbg_addr;
  logic [INSTRUCTION_LENGTH-1:0] dbg_instr;
  logic                          dbg_rd_en;
  logic [INSTRUCTION_LENGTH-1:0] dbg_rd_data;
  logic                          dbg_rd_valid;
  logic                          dbg_err;
  logic                          fetch_en;
  logic [XLEN-1:0]               fetch_addr;
  logic [INSTRUCTION_LENGTH-1:0] fetch_instr;
  logic                          fetch_valid;
  logic                          core_hold;
  logic [15:0]                   load_count;

  modport master (
    output dbg_wr_en, dbg_addr, dbg_instr, dbg_rd_en, fetch_en, fetch_addr,
    input  dbg_rd_data, dbg_rd_valid, dbg_err, fetch_instr, fetch_valid,
           core_hold, load_count
  );

  modport slave (
    input  dbg_wr_en, dbg_addr, dbg_instr, dbg_rd_en, fetch_en, fetch_addr,
    output dbg_rd_data, dbg_rd_valid, dbg_err, fetch_instr, fetch_valid,
           core_hold, load_count
  );
endinterface

// File: rtl/dbg_imem_port.sv
// Word-addressed instruction store loaded over the debug port; serves registered
// core fetches and debug read-back, and stalls the core while code is loading.
module dbg_imem_port #(
  parameter int XLEN               = 64,
  parameter int INSTRUCTION_LENGTH = XLEN / 2,
  parameter int DEPTH              = 256
) (
  input logic            clk,
  input logic            rst,
  dbg_imem_port_if.slave bus
);
  localparam int IL = INSTRUCTION_LENGTH;
  localparam int AW = $clog2(DEPTH);
  localparam logic [IL-1:0] NOP = IL'(32'h0000_0013);

  localparam logic [1:0] ST_HOLD  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic [IL-1:0] mem_q [DEPTH];

  logic [1:0]    state_q, state_d;
  logic          drain_cnt_q, drain_cnt_d;
  logic [15:0]   load_count_q, load_count_d;
  logic          err_q, err_d;
  logic [IL-1:0] rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic [IL-1:0] fetch_instr_q, fetch_instr_d;
  logic          fetch_valid_q, fetch_valid_d;

  logic          dbg_legal, fetch_legal;
  logic [AW-1:0] dbg_idx, fetch_idx;
  logic          wr_ok, wr_bad, rd_req, rd_ok, fetch_ok;

  // DEPTH is a power of two, so "below DEPTH*4" is "all bits above the index are zero"
  assign dbg_legal   = (bus.dbg_addr[1:0] == 2'b00) && (bus.dbg_addr[IL-1:AW+2] == '0);
  assign fetch_legal = (bus.fetch_addr[1:0] == 2'b00) && (bus.fetch_addr[XLEN-1:AW+2] == '0);
  assign dbg_idx     = bus.dbg_addr[AW+1:2];
  assign fetch_idx   = bus.fetch_addr[AW+1:2];

  assign wr_ok    = bus.dbg_wr_en && dbg_legal;
  assign wr_bad   = bus.dbg_wr_en && !dbg_legal && !rst;
  assign rd_req   = bus.dbg_rd_en && !bus.dbg_wr_en && !rst;
  assign rd_ok    = rd_req && dbg_legal;
  assign fetch_ok = bus.fetch_en && fetch_legal && (state_q == ST_RUN);

  // Store has no reset so a loader can preload code while the core is in reset
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[dbg_idx] <= bus.dbg_instr;
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    if (wr_ok) begin
      state_d     = ST_HOLD;
      drain_cnt_d = 1'b0;
    end else if (!bus.dbg_wr_en) begin
      case (state_q)
        ST_HOLD: begin
          state_d     = ST_DRAIN;
          drain_cnt_d = 1'b0;
        end
        ST_DRAIN: begin
          if (drain_cnt_q) state_d = ST_RUN;
          else             drain_cnt_d = 1'b1;
        end
        ST_RUN:  ;
        default: state_d = ST_HOLD;
      endcase
    end
  end

  always_comb begin
    load_count_d = load_count_q;
    if (wr_ok && (load_count_q != 16'hFFFF)) load_count_d = load_count_q + 16'd1;

    err_d = err_q | wr_bad | (rd_req && !dbg_legal);

    rd_valid_d = rd_ok;
    rd_data_d  = rd_data_q;
    if (rd_req) rd_data_d = dbg_legal ? mem_q[dbg_idx] : '0;

    // A fetch on the write cycle sees the pre-write word; that is intended
    fetch_valid_d = fetch_ok;
    fetch_instr_d = fetch_ok ? mem_q[fetch_idx] : NOP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_HOLD;
      drain_cnt_q   <= 1'b0;
      load_count_q  <= '0;
      err_q         <= 1'b0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      fetch_instr_q <= NOP;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      load_count_q  <= load_count_d;
      err_q         <= err_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      fetch_instr_q <= fetch_instr_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  assign bus.core_hold    = (state_q != ST_RUN);
  assign bus.load_count   = load_count_q;
  assign bus.dbg_err      = err_q;
  assign bus.dbg_rd_data  = rd_data_q;
  assign bus.dbg_rd_valid = rd_valid_q;
  assign bus.fetch_instr  = fetch_instr_q;
  assign bus.fetch_valid  = fetch_valid_q;
endmodule

// File: tb/tb_dbg_imem_port.sv
// Vector table plus scoreboard for dbg_imem_port: read/fetch results are queued
// from a reference store when issued and popped when the DUT returns them.
module tb_dbg_imem_port;
  localparam int XLEN  = 64;
  localparam int IL    = 32;
  localparam int DEPTH = 256;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dbg_imem_port_if #(.XLEN(XLEN), .INSTRUCTION_LENGTH(IL)) bus();
  dbg_imem_port #(.XLEN(XLEN), .INSTRUCTION_LENGTH(IL), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int passed = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] rd_q[$];
  logic [31:0] fe_q[$];

  typedef struct {
    logic        rst, we;
    logic [31:0] addr, data;
    logic        re, fe;
    logic [63:0] faddr;
    logic        run;
    logic        hold, rdv, err, fv;
    logic [15:0] cnt;
  } vec_t;
  vec_t vecs[$];

  function automatic logic dlegal(logic [31:0] a);
    return (a % 4 == 0) && (a < 32'h400);
  endfunction

  function automatic logic flegal(logic [63:0] a);
    return (a % 4 == 0) && (a < 64'h400);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
  endtask

  task automatic add(logic r, logic we, logic [31:0] a, logic [31:0] d, logic re,
                     logic fe, logic [63:0] fa, logic run,
                     logic hold, logic rdv, logic err, logic fv, logic [15:0] cnt);
    vec_t v;
    v.rst = r; v.we = we; v.addr = a; v.data = d; v.re = re; v.fe = fe;
    v.faddr = fa; v.run = run; v.hold = hold; v.rdv = rdv; v.err = err;
    v.fv = fv; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  // run: the bench knows the DUT is in RUN this cycle, so a legal fetch must return
  task automatic cyc(logic r, logic we, logic [31:0] a, logic [31:0] d, logic re,
                     logic fe, logic [63:0] fa, logic run);
    rst = r;
    bus.dbg_wr_en = we; bus.dbg_addr = a; bus.dbg_instr = d; bus.dbg_rd_en = re;
    bus.fetch_en = fe; bus.fetch_addr = fa;
    if (!r && re && !we && dlegal(a)) rd_q.push_back(model[a[9:2]]);
    if (!r && fe && run && flegal(fa)) fe_q.push_back(model[fa[9:2]]);
    if (we && dlegal(a)) model[a[9:2]] = d;
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #2;
    if (bus.dbg_rd_valid === 1'b1) begin
      if (rd_q.size() == 0) begin
        checks++;
        $display("FAIL rd_unexpected: got valid %0h, required no result at %0t", bus.dbg_rd_data, $time);
      end else chk("rd_data", bus.dbg_rd_data, rd_q.pop_front());
    end
    if (bus.fetch_valid === 1'b1) begin
      if (fe_q.size() == 0) begin
        checks++;
        $display("FAIL fetch_unexpected: got valid %0h, required no result at %0t", bus.fetch_instr, $time);
      end else chk("fetch_instr", bus.fetch_instr, fe_q.pop_front());
    end
  end

  initial begin
    rst = 1'b1;
    bus.dbg_wr_en = 1'b0; bus.dbg_addr = '0; bus.dbg_instr = '0; bus.dbg_rd_en = 1'b0;
    bus.fetch_en = 1'b0; bus.fetch_addr = '0;

    // rst we addr data re fe faddr run | hold rdv err fv cnt
    add(1, 0, 'h0,   0,           0, 0, 'h0, 0,  1, 0, 0, 0, 0);
    add(1, 1, 'h0,   'h0020B0B7,  0, 0, 'h0, 0,  1, 0, 0, 0, 0);
    add(0, 0, 'h0,   0,           0, 0, 'h0, 0,  1, 0, 0, 0, 0);
    add(0, 0, 'h0,   0,           0, 0, 'h0, 0,  1, 0, 0, 0, 0);
    add(0, 0, 'h0,   0,           0, 0, 'h0, 0,  0, 0, 0, 0, 0);
    add(0, 0, 'h0,   0,           0, 1, 'h0, 1,  0, 0, 0, 1, 0);
    add(0, 1, 'h4,   'h00000013,  0, 0, 'h0, 0,  1, 0, 0, 0, 1);
    add(0, 1, 'h8,   'h00108093,  0, 0, 'h0, 0,  1, 0, 0, 0, 2);
    add(0, 1, 'h3FC, 'hFFFFFFFF,  0, 0, 'h0, 0,  1, 0, 0, 0, 3);
    add(0, 0, 'h4,   0,           1, 0, 'h0, 0,  1, 1, 0, 0, 3);
    add(0, 0, 'h8,   0,           1, 0, 'h0, 0,  1, 1, 0, 0, 3);
    add(0, 0, 'h3FC, 0,           1, 0, 'h0, 0,  0, 1, 0, 0, 3);
    add(0, 1, 'h20,  'h0BADF00D,  1, 0, 'h0, 0,  1, 0, 0, 0, 4);
    add(0, 0, 'h20,  0,           1, 0, 'h0, 0,  1, 1, 0, 0, 4);
    add(0, 0, 'h0,   0,           0, 0, 'h0, 0,  1, 0, 0, 0, 4);
    add(0, 0, 'h0,   0,           0, 0, 'h0, 0,  0, 0, 0, 0, 4);
    add(0, 1, 'h2,   'hDEADBEEF,  0, 0, 'h0, 0,  0, 0, 1, 0, 4);
    add(0, 1, 'h400, 'hCAFEF00D,  0, 0, 'h0, 0,  0, 0, 1, 0, 4);
    add(0, 0, 'h401, 0,           1, 0, 'h0, 0,  0, 0, 1, 0, 4);
    add(0, 0, 'h0,   0,           1, 0, 'h0, 0,  0, 1, 1, 0, 4);
    add(0, 0, 'h0,   0,           0, 1, 'h0, 1,  0, 0, 1, 1, 4);
    add(0, 1, 'h10,  'h12345678,  0, 1, 'h0, 1,  1, 0, 1, 1, 5);
    add(0, 0, 'h0,   0,           0, 1, 'h4, 0,  1, 0, 1, 0, 5);
    add(0, 0, 'h0,   0,           0, 1, 'h8, 0,  1, 0, 1, 0, 5);
    add(0, 0, 'h0,   0,           0, 1, 'hC, 0,  0, 0, 1, 0, 5);
    add(0, 0, 'h0,   0,           0, 1, 'h10, 1, 0, 0, 1, 1, 5);
    add(0, 1, 'h10,  'hA5A5A5A5,  0, 1, 'h10, 1, 1, 0, 1, 1, 6);
    add(0, 0, 'h0,   0,           0, 0, 'h0, 0,  1, 0, 1, 0, 6);
    add(0, 0, 'h0,   0,           0, 0, 'h0, 0,  1, 0, 1, 0, 6);
    add(0, 0, 'h0,   0,           0, 0, 'h0, 0,  0, 0, 1, 0, 6);
    add(0, 0, 'h0,   0,           0, 1, 'h10, 1, 0, 0, 1, 1, 6);
    add(0, 0, 'h0,   0,           0, 1, 64'h1_0000_0000, 1, 0, 0, 1, 0, 6);
    add(0, 0, 'h0,   0,           0, 1, 'h6, 1,  0, 0, 1, 0, 6);
    add(0, 0, 'h0,   0,           0, 1, 'h3FC, 1, 0, 0, 1, 1, 6);
    add(0, 0, 'h0,   0,           0, 1, 'h400, 1, 0, 0, 1, 0, 6);
    add(0, 0, 'h0,   0,           0, 1, 'h8, 1,  0, 0, 1, 1, 6);
    add(1, 0, 'h8,   0,           1, 1, 'h0, 0,  1, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].re,
          vecs[i].fe, vecs[i].faddr, vecs[i].run);
      chk($sformatf("v%0d_core_hold", i), bus.core_hold, vecs[i].hold);
      chk($sformatf("v%0d_rd_valid", i), bus.dbg_rd_valid, vecs[i].rdv);
      chk($sformatf("v%0d_dbg_err", i), bus.dbg_err, vecs[i].err);
      chk($sformatf("v%0d_fetch_valid", i), bus.fetch_valid, vecs[i].fv);
      chk($sformatf("v%0d_load_count", i), bus.load_count, vecs[i].cnt);
      if (!vecs[i].fv) chk($sformatf("v%0d_fetch_nop", i), bus.fetch_instr, NOP);
      if (vecs[i].rst) chk($sformatf("v%0d_rd_data_rst", i), bus.dbg_rd_data, 0);
    end

    // Release after mid-operation reset: store must survive, hold drops after 3 edges
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 'h0, 0, 0, 0, 'h0, 0);
      chk($sformatf("rel%0d_core_hold", k), bus.core_hold, (k < 2) ? 1'b1 : 1'b0);
      chk($sformatf("rel%0d_load_count", k), bus.load_count, 0);
    end
    cyc(0, 0, 'h8, 0, 1, 0, 'h0, 0);
    chk("rel_rd_valid", bus.dbg_rd_valid, 1);
    chk("rel_err_clear", bus.dbg_err, 0);
    cyc(0, 0, 'h401, 0, 1, 0, 'h0, 0);
    chk("bad_rd_valid", bus.dbg_rd_valid, 0);
    chk("bad_rd_err", bus.dbg_err, 1);
    chk("bad_rd_data", bus.dbg_rd_data, 0);
    cyc(0, 0, 'h3FC, 0, 1, 0, 'h0, 0);
    chk("last_rd_valid", bus.dbg_rd_valid, 1);
    cyc(0, 0, 'h0, 0, 0, 0, 'h0, 0);
    chk("rd_valid_pulse", bus.dbg_rd_valid, 0);
    cyc(0, 0, 'h0, 0, 0, 0, 'h0, 0);
    #3;
    chk("rd_q_drained", rd_q.size(), 0);
    chk("fe_q_drained", fe_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/dbg_imem_port.md
# dbg_imem_port

Responder side of the core's debug instruction-load interface. It accepts `dbg_wr_en`/`dbg_addr`/`dbg_instr` word writes from a bench or host loader and commits them to a word-addressed instruction store. It serves registered instruction fetches to the core and provides a debug read-back path. While a load is in progress and for a fixed drain window afterwards, it holds the core off (`core_hold`), so the pipeline never fetches partially loaded code.

## Interface
- `XLEN`, 64, core datapath width; width of the fetch address.
- `INSTRUCTION_LENGTH`, `XLEN/2`, instruction width and debug address/data width.
- `DEPTH`, 256, instruction store depth in words; power of two.
- `clk` input 1: single clock, all logic rising-edge.
- `rst` input 1: reset, synchronous and active-high.
- `dbg_wr_en` input 1: debug write strobe, one word per cycle.
- `dbg_addr` input `INSTRUCTION_LENGTH`: debug byte address, shared by write and read.
- `dbg_instr` input `INSTRUCTION_LENGTH`: debug write data.
- `dbg_rd_en` input 1: debug read strobe.
- `dbg_rd_data` output `INSTRUCTION_LENGTH`: read-back word.
- `dbg_rd_valid` output 1: `dbg_rd_data` is valid this cycle.
- `dbg_err` output 1: sticky flag for a rejected access.
- `fetch_en` input 1: core fetch request.
- `fetch_addr` input `XLEN`: core PC, as a byte address.
- `fetch_instr` output `INSTRUCTION_LENGTH`: fetched instruction.
- `fetch_valid` output 1: `fetch_instr` is valid.
- `core_hold` output 1: core must stall or keep its PC.
- `load_count` output 16: accepted debug writes since reset, saturating.

## Operation
- **Address check:** an access is legal when `addr[1:0]==0` and `addr < DEPTH*4`. The word index is `addr[$clog2(DEPTH)+1:2]`.
- **Store contents:** the store is never cleared by reset.
- **Writes during reset:** a legal write while `rst=1` is committed to the store. No other state changes during reset: it is not counted and does not set `dbg_err`.
- **Legal write while `rst=0`:**
  - commits to the store;
  - increments `load_count`, saturating at 0xFFFF;
  - forces state to HOLD.
- **Illegal write:** no store update and no state change. Sets `dbg_err` when `rst=0`.
- **Simultaneous write and read:** if `dbg_wr_en` and `dbg_rd_en` are both high, the write wins. The read is dropped: no `dbg_rd_valid`, no error.
- **Debug read:** a legal read returns store data. An illegal read returns 0, leaves `dbg_rd_valid` at 0, and sets `dbg_err`. Reads are ignored while `rst=1`.
- **`dbg_err`:** cleared only by reset.
- **State machine:**
  - **HOLD** (reset state, `core_hold=1`): goes to DRAIN on the first cycle with `rst=0` and `dbg_wr_en=0`.
  - **DRAIN** (`core_hold=1`): a 2-cycle counter. A legal write returns to HOLD; otherwise goes to RUN after 2 cycles.
  - **RUN** (`core_hold=0`): a legal write goes to HOLD in the same cycle, so `core_hold` rises on the next edge.
- **Fetch:** `fetch_valid` requires all of:
  - a fetch request in a cycle where state is RUN;
  - `fetch_addr` aligned and within range, with the upper `XLEN` bits checked too.
  
  Otherwise `fetch_instr` is the NOP 0x00000013 and `fetch_valid` is 0. Illegal fetches do not set `dbg_err`.
- **Fetch on the write cycle:** a RUN-state fetch in the same cycle as a legal write returns old data. It is still valid, because the fetch sampled RUN.

## Timing
- **Reset values:**
  - `dbg_rd_data` = 0, `dbg_rd_valid` = 0, `dbg_err` = 0;
  - `fetch_instr` = 0x00000013, `fetch_valid` = 0;
  - `core_hold` = 1, `load_count` = 0.
- **Write:** the store updates at the edge that samples `dbg_wr_en`. Data is visible to a read or fetch issued in the next cycle.
- **Debug read:** 1-cycle latency. `dbg_rd_data`/`dbg_rd_valid` are registered, and `dbg_rd_valid` is a single-cycle pulse per accepted read.
- **Fetch:** 1-cycle latency, registered. Back-to-back fetches give one result per cycle.
- **`core_hold` release:** with `rst` low and no writes from cycle N, the state is DRAIN at N+1 and N+2 and RUN at N+3. `core_hold` falls at edge N+3.
- **`core_hold` assertion:** a legal write in RUN at cycle N gives `core_hold=1` from edge N+1.
- **Reset mid-operation:** state returns to HOLD and all outputs take their reset values on the next edge. A pending read result is discarded.

## Test plan
- **Write during reset:** `rst=1`, write 0x0020B0B7 to addr 0, release `rst` → `core_hold` falls exactly 3 cycles after `rst` deasserts, `load_count=0`, fetch of addr 0 returns 0x0020B0B7 with `fetch_valid=1` one cycle later.
- **Load then read back:** write 0x00000013 to 0x4, 0x00108093 to 0x8, 0xFFFFFFFF to 0x3FC; read each → `dbg_rd_data` matches one cycle after `dbg_rd_en`, `load_count=3`, `dbg_err=0`.
- **Illegal accesses:** write to 0x2 and write to 0x400 (DEPTH=256) → store unchanged, `load_count` unchanged, `dbg_err=1` and stays high until `rst`; read of 0x401 → `dbg_rd_valid=0`.
- **Write while running:** in RUN, fetch streaming from 0x0 and a write to 0x10 → `core_hold=1` next cycle, `fetch_valid` low while held, RUN resumes 3 cycles after the write, and a fetch of 0x10 returns the new word.
- **Simultaneous write and read:** `dbg_wr_en=1` and `dbg_rd_en=1` to 0x20 → write committed, no `dbg_rd_valid`, no error.
- **Reset mid-operation:** `rst` asserted mid-read and during RUN → next edge all outputs at reset values, store contents preserved, and a read after release returns the previously loaded data.
